// File: rtl/adc_stream_pkg.sv
// Shared constants and types for the ADC sample stream and burst packer.
// Flags live in word bits [31:30]; PAD_WORD carries the pad flag.
package adc_stream_pkg;

    localparam logic [1:0] FLAG_NORMAL = 2'b00;
    localparam logic [1:0] FLAG_BELOW  = 2'b10;
    localparam logic [1:0] FLAG_END    = 2'b11;
    localparam logic [1:0] FLAG_PAD    = 2'b01;

    localparam logic [31:0] PAD_WORD = {FLAG_PAD, 30'h0};

    // FIFO entry {tlast, data} written in place of a dropped series end
    localparam logic [32:0] PAD_LAST = {1'b1, PAD_WORD};

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        PAD
    } fsm_state_t;

endpackage

// File: rtl/adc_packer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy and tlast count.
// Ports: aclk, aresetn (async active-low), push/push_data, pop, head,
//        full, level (0..2**AW), last_cnt (entries whose top bit is set).
module adc_packer_fifo #(
    parameter int AW = 9,
    parameter int DW = 33
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic [AW:0]   level,
    output logic [AW:0]   last_cnt
);

    localparam logic [AW:0]   DEPTH = (AW + 1)'(2 ** AW);
    localparam logic [AW:0]   L_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] P_ONE = AW'(1);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic          in_last;
    logic          out_last;

    assign full     = (level == DEPTH);
    assign do_pop   = pop && (level != '0);
    // A pop on a full FIFO frees the slot for a same-cycle push
    assign do_push  = push && (!full || do_pop);
    assign head     = mem[rd_ptr];
    assign in_last  = do_push && push_data[DW-1];
    assign out_last = do_pop && head[DW-1];

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + L_ONE;
                2'b01:   level <= level - L_ONE;
                default: level <= level;
            endcase
            unique case ({in_last, out_last})
                2'b10:   last_cnt <= last_cnt + L_ONE;
                2'b01:   last_cnt <= last_cnt - L_ONE;
                default: last_cnt <= last_cnt;
            endcase
        end
    end

endmodule

// File: rtl/adc_burst_packer.sv
// Buffers the ADC sample stream and re-emits fixed BURST_LEN-word AXI-Stream
// bursts; series ends are padded to a full burst, overflow words are dropped
// and counted.
// Ports: aclk, aresetn (async active-low); s_axis_* input (no tready);
//        m_axis_* output with backpressure; nclear_stats (sync active-low)
//        clears overflow_count, overflow_flag, bursts_sent; fifo_level.
// Optional macro ADC_PACKER_TIMEOUT_EN: flush a partial burst after
// TIMEOUT_CYC idle cycles.
module adc_burst_packer
    import adc_stream_pkg::*;
#(
    parameter int BURST_LEN   = 32,
    parameter int FIFO_AW     = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic [31:0]      s_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [31:0]      m_axis_tdata,
    input  logic             nclear_stats,
    output logic [15:0]      overflow_count,
    output logic             overflow_flag,
    output logic [31:0]      bursts_sent,
    output logic [FIFO_AW:0] fifo_level
);

    localparam int            BW        = $clog2(BURST_LEN);
    localparam int            LW        = FIFO_AW + 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [LW-1:0] LEN_LVL   = LW'(BURST_LEN);

    fsm_state_t    state;
    logic [BW-1:0] beat;
    logic [BW-1:0] beat_next;

    logic [32:0]   fifo_head;
    logic          fifo_full;
    logic [LW-1:0] last_cnt;

    logic          handshake;
    logic          pop;
    logic          can_write;
    logic          wr_en;
    logic [32:0]   wr_data;
    logic          drop;
    logic          set_pend;
    logic          clr_pend;
    logic          pend_last;

    logic          start_burst;
    logic          timeout_hit;
    logic          timed_end;

    assign handshake = m_axis_tvalid && m_axis_tready;
    assign pop       = handshake && (state == STREAM);
    assign can_write = !fifo_full || pop;
    assign beat_next = beat + BEAT_ONE;

    // Write path: a pending series end takes priority over new input
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = {s_axis_tlast, s_axis_tdata};
        drop     = 1'b0;
        set_pend = 1'b0;
        clr_pend = 1'b0;
        if (can_write) begin
            if (pend_last) begin
                wr_en    = 1'b1;
                wr_data  = PAD_LAST;
                clr_pend = 1'b1;
                drop     = s_axis_tvalid;
            end else if (s_axis_tvalid) begin
                wr_en = 1'b1;
            end
        end else if (s_axis_tvalid) begin
            drop     = 1'b1;
            set_pend = s_axis_tlast;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_last <= 1'b0;
        end else if (set_pend) begin
            pend_last <= 1'b1;
        end else if (clr_pend) begin
            pend_last <= 1'b0;
        end
    end

    adc_packer_fifo #(
        .AW (FIFO_AW),
        .DW (33)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .level     (fifo_level),
        .last_cnt  (last_cnt)
    );

`ifdef ADC_PACKER_TIMEOUT_EN
    localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [LW-1:0] L_ONE = LW'(1);

    logic [TW-1:0] idle_cnt;
    logic          partial;
    logic          timed;
    logic [LW-1:0] data_left;

    assign partial = (state == IDLE) && (fifo_level != '0)
                  && (fifo_level < LEN_LVL) && (last_cnt == '0);
    assign timeout_hit = partial && (idle_cnt == T_END);
    assign timed_end   = timed && (data_left == L_ONE);

    // data_left: words of a timed-out burst still to pop before padding
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idle_cnt  <= '0;
            timed     <= 1'b0;
            data_left <= '0;
        end else begin
            if (wr_en || !partial) begin
                idle_cnt <= '0;
            end else if (!timeout_hit) begin
                idle_cnt <= idle_cnt + T_ONE;
            end
            if (state == IDLE) begin
                timed     <= timeout_hit;
                data_left <= fifo_level;
            end else if (pop) begin
                data_left <= data_left - L_ONE;
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign timed_end      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    assign start_burst = (fifo_level >= LEN_LVL) || (last_cnt != '0)
                      || timeout_hit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            beat          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    beat <= '0;
                    if (start_burst) begin
                        state         <= STREAM;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                STREAM, PAD: begin
                    if (handshake) begin
                        if (beat == BEAT_LAST) begin
                            state         <= IDLE;
                            beat          <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            beat         <= beat_next;
                            m_axis_tlast <= (beat_next == BEAT_LAST);
                            if (state == STREAM
                                && (fifo_head[32] || timed_end)) begin
                                state <= PAD;
                            end
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    beat          <= '0;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

    // Head is stable until popped, so tdata holds while stalled
    always_comb begin
        m_axis_tdata = 32'h0;
        unique case (state)
            STREAM:  m_axis_tdata = fifo_head[31:0];
            PAD:     m_axis_tdata = PAD_WORD;
            default: m_axis_tdata = 32'h0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_count <= '0;
            overflow_flag  <= 1'b0;
            bursts_sent    <= '0;
        end else if (!nclear_stats) begin
            overflow_count <= '0;
            overflow_flag  <= 1'b0;
            bursts_sent    <= '0;
        end else begin
            if (drop) begin
                overflow_flag <= 1'b1;
                if (overflow_count != 16'hFFFF) begin
                    overflow_count <= overflow_count + 16'd1;
                end
            end
            if (handshake && m_axis_tlast) begin
                bursts_sent <= bursts_sent + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_burst_packer.sv
// Self-checking bench for adc_burst_packer (BURST_LEN=32, FIFO_AW=9).
// A burst model fills an expected-beat queue that the output monitor drains.
module tb_adc_burst_packer;

    localparam logic [31:0] PADW = 32'h4000_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] s_axis_tdata = 32'h0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        nclear_stats = 1'b1;
    logic [15:0] overflow_count;
    logic        overflow_flag;
    logic [31:0] bursts_sent;
    logic [9:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    int exp_bursts = 0;

    logic [32:0] exp_q[$];
    logic [32:0] pend_q[$];

    typedef struct {
        int n;
        bit last;
        int bursts;
        int level;
    } vec_t;

    vec_t tbl[7];

    always #5 aclk = ~aclk;

    adc_burst_packer #(
        .BURST_LEN   (32),
        .FIFO_AW     (9),
        .TIMEOUT_CYC (1024)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdata   (s_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .nclear_stats   (nclear_stats),
        .overflow_count (overflow_count),
        .overflow_flag  (overflow_flag),
        .bursts_sent    (bursts_sent),
        .fifo_level     (fifo_level)
    );

    function automatic void model_flush();
        while (pend_q.size() < 32) pend_q.push_back({1'b0, PADW});
        for (int i = 0; i < 32; i++)
            exp_q.push_back({(i == 31), pend_q[i][31:0]});
        pend_q.delete();
    endfunction

    function automatic void model_push(input logic [31:0] d, input logic l);
        pend_q.push_back({1'b0, d});
        if (pend_q.size() == 32 || l) model_flush();
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send(input int n, input bit last, input bit modeled);
        logic [31:0] r;
        logic [31:0] d;
        logic        l;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            d = {2'b00, r[29:0]};
            l = last && (i == n - 1);
            if (modeled) model_push(d, l);
            drive(d, l);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        repeat (4) @(posedge aclk);
        #1;
        chk({name, " drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: scoreboard, hold-while-stalled and no-gap checks
    initial begin : monitor
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = 32'h0;
        logic        prev_last = 1'b0;
        logic        in_burst = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                in_burst   = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!m_axis_tvalid || m_axis_tdata !== prev_data
                        || m_axis_tlast !== prev_last) begin
                        failures++;
                        $display("FAIL hold: got v%0b %h l%0b required v1 %h l%0b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                                 prev_data, prev_last);
                    end
                end
                if (in_burst) begin
                    checks++;
                    if (m_axis_tvalid !== 1'b1) begin
                        failures++;
                        $display("FAIL gap: got tvalid %0b required 1",
                                 m_axis_tvalid);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL beat: got unexpected %0b/%h required none",
                                 m_axis_tlast, m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_axis_tlast, m_axis_tdata} !== e) begin
                            failures++;
                            $display("FAIL beat: got %0b/%h required %0b/%h",
                                     m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
                        end
                    end
                    in_burst = !m_axis_tlast;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n: 64, last: 1'b0, bursts: 2, level: 0};
        tbl[1] = '{n: 5,  last: 1'b1, bursts: 1, level: 0};
        tbl[2] = '{n: 32, last: 1'b1, bursts: 1, level: 0};
        tbl[3] = '{n: 1,  last: 1'b1, bursts: 1, level: 0};
        tbl[4] = '{n: 40, last: 1'b0, bursts: 1, level: 8};
        tbl[5] = '{n: 24, last: 1'b1, bursts: 1, level: 0};
        tbl[6] = '{n: 33, last: 1'b1, bursts: 2, level: 0};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst tdata", m_axis_tdata, 32'd0);
        chk("rst ovf_cnt", 32'(overflow_count), 32'd0);
        chk("rst ovf_flag", 32'(overflow_flag), 32'd0);
        chk("rst bursts", bursts_sent, 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Table-driven bursts with tready held high
        for (int v = 0; v < 7; v++) begin
            send(tbl[v].n, tbl[v].last, 1'b1);
            wait_drain($sformatf("vec%0d", v));
            exp_bursts += tbl[v].bursts;
            chk($sformatf("vec%0d bursts", v), bursts_sent, 32'(exp_bursts));
            chk($sformatf("vec%0d level", v), 32'(fifo_level),
                32'(tbl[v].level));
        end
        chk("vec ovf_cnt", 32'(overflow_count), 32'd0);

        // Overflow with writer stalled
        m_axis_tready = 1'b0;
        send(512, 1'b0, 1'b1);
        send(88, 1'b0, 1'b0);
        chk("ovf level", 32'(fifo_level), 32'd512);
        chk("ovf cnt", 32'(overflow_count), 32'd88);
        chk("ovf flag", 32'(overflow_flag), 32'd1);
        chk("ovf tvalid", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        wait_drain("ovf");
        exp_bursts += 16;
        chk("ovf bursts", bursts_sent, 32'(exp_bursts));
        chk("ovf flag sticky", 32'(overflow_flag), 32'd1);

        // Statistics clear
        nclear_stats = 1'b0;
        @(posedge aclk); #1;
        nclear_stats = 1'b1;
        exp_bursts = 0;
        chk("clr ovf_cnt", 32'(overflow_count), 32'd0);
        chk("clr ovf_flag", 32'(overflow_flag), 32'd0);
        chk("clr bursts", bursts_sent, 32'd0);

        // Random backpressure during bursts
        fork
            send(96, 1'b0, 1'b1);
            begin
                repeat (400) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    @(posedge aclk); #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_drain("rand");
        exp_bursts += 3;
        chk("rand bursts", bursts_sent, 32'(exp_bursts));

        // Series end dropped on a full FIFO
        m_axis_tready = 1'b0;
        send(512, 1'b0, 1'b1);
        drive(32'h1234_5678, 1'b1);
        drive(32'h0abc_def0, 1'b0);
        chk("full level", 32'(fifo_level), 32'd512);
        chk("full ovf_cnt", 32'(overflow_count), 32'd2);
        chk("full ovf_flag", 32'(overflow_flag), 32'd1);
        m_axis_tready = 1'b1;
        drive(32'h0555_aaaa, 1'b0);
        model_push(PADW, 1'b1);
        model_push(32'h0777_1111, 1'b1);
        drive(32'h0777_1111, 1'b1);
        wait_drain("full");
        exp_bursts += 18;
        chk("full bursts", bursts_sent, 32'(exp_bursts));
        chk("full ovf_cnt2", 32'(overflow_count), 32'd3);
        chk("full level2", 32'(fifo_level), 32'd0);

        // Partial burst without series end
        send(3, 1'b0, 1'b1);
`ifdef ADC_PACKER_TIMEOUT_EN
        model_flush();
        wait_drain("tmo");
        exp_bursts += 1;
        chk("tmo bursts", bursts_sent, 32'(exp_bursts));
        chk("tmo level", 32'(fifo_level), 32'd0);
`else
        repeat (300) @(posedge aclk);
        #1;
        chk("part level", 32'(fifo_level), 32'd3);
        chk("part tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("part bursts", bursts_sent, 32'(exp_bursts));
`endif

        // Reset in the middle of a stalled burst
        m_axis_tready = 1'b0;
        send(40, 1'b0, 1'b1);
        repeat (2) @(posedge aclk);
        #1;
        chk("mid tvalid", 32'(m_axis_tvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("mid rst tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid rst tlast", 32'(m_axis_tlast), 32'd0);
        chk("mid rst tdata", m_axis_tdata, 32'd0);
        chk("mid rst level", 32'(fifo_level), 32'd0);
        chk("mid rst bursts", bursts_sent, 32'd0);
        chk("mid rst ovf_cnt", 32'(overflow_count), 32'd0);
        exp_q.delete();
        pend_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        repeat (50) @(posedge aclk);
        #1;
        chk("post rst tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("post rst level", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
